vmsu_seq_mult: RTL and testbench

Parametrised sequential multiplier, the successor to the fixed 8-bit combinational VMSU multiplier on the user project. Computes a WIDTH×WIDTH product, signed or unsigned selected per operation, over WIDTH+2 cycles using one shift-add stage instead of a full array. A start/ready/done handshake lets it be driven from logic-analyzer bits or a controller FSM. An optional compile-time multiply-accumulate mode is provided.

---
 rtl/vmsu_seq_mult.sv | 145 ++++++++++++++
 tb/tb_vmsu_seq_mult.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmsu_seq_mult.sv
// Sequential shift-add WIDTH x WIDTH multiplier (signed/unsigned per operation), start/ready/done handshake.
// Define VMSU_MAC_EN to turn p_o into an accumulator cleared by acc_clr_i.
module vmsu_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    input  logic                 acc_clr_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_ready;
    logic               w_busy;
    logic               w_last;

    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [PW-1:0]      r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_p;
    logic               r_done;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_result;

`ifndef VMSU_MAC_EN
    logic               w_unused_acc_clr;
    assign w_unused_acc_clr = acc_clr_i;
`endif

    // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude
    assign w_a_mag  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_mag  = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_result = r_neg ? -r_sum : r_sum;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (start_i) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_busy = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Multiplicand shifts left and multiplier right each step; equivalent to adding a << cnt when b[cnt] is set
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef VMSU_MAC_EN
                    if (acc_clr_i) begin
                        r_p <= '0;
                    end
`endif
                    if (start_i) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        r_sum    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_sum    <= r_sum + w_addend;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                FIX: begin
`ifdef VMSU_MAC_EN
                    r_p <= r_p + w_result;
`else
                    r_p <= w_result;
`endif
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready_o = w_ready;
    assign busy_o  = w_busy;
    assign done_o  = r_done;
    assign p_o     = r_p;

endmodule

// File: tb/tb_vmsu_seq_mult.sv
// Scoreboard bench for vmsu_seq_mult: WIDTH=8 instance driven through a queue model, plus a WIDTH=16 directed case.
// Expectations follow VMSU_MAC_EN when the bench is built with it.
module tb_vmsu_seq_mult;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, sgn, acc_clr;
    logic [W-1:0]   a, b;
    logic           ready, busy, done;
    logic [2*W-1:0] p;

    logic           start16, sgn16, acc_clr16;
    logic [15:0]    a16, b16;
    logic           ready16, busy16, done16;
    logic [31:0]    p16;

    vmsu_seq_mult #(.WIDTH(W)) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start_i  (start),
        .a_i      (a),
        .b_i      (b),
        .signed_i (sgn),
        .acc_clr_i(acc_clr),
        .ready_o  (ready),
        .busy_o   (busy),
        .done_o   (done),
        .p_o      (p)
    );

    vmsu_seq_mult #(.WIDTH(16)) u_dut16 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start_i  (start16),
        .a_i      (a16),
        .b_i      (b16),
        .signed_i (sgn16),
        .acc_clr_i(acc_clr16),
        .ready_o  (ready16),
        .busy_o   (busy16),
        .done_o   (done16),
        .p_o      (p16)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_fail   = 0;
    int unsigned    cyc      = 0;
    logic [15:0]    exp_q[$];
    int unsigned    acc_cyc_q[$];
    logic [15:0]    m_acc    = '0;
    int             n_done   = 0;
    int             n_accept = 0;
    int unsigned    last_done_cyc = 0;
    int unsigned    prev_done_cyc = 0;
    logic           prev_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi, yi, pr;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        pr = xi * yi;
        return pr[15:0];
    endfunction

    // Accepting edges push the expected p_o
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_cyc_q.delete();
            m_acc = '0;
        end else if (ready) begin
`ifdef VMSU_MAC_EN
            if (acc_clr) m_acc = '0;
            if (start) begin
                m_acc = m_acc + model(a, b, sgn);
                exp_q.push_back(m_acc);
            end
`else
            if (start) exp_q.push_back(model(a, b, sgn));
`endif
            if (start) begin
                acc_cyc_q.push_back(cyc);
                n_accept++;
            end
        end
    end

    always @(negedge clk) begin
        check("busy_xor_ready", busy ^ ready, 1);
        if (done) begin
            n_done++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            check("done_consecutive", {prev_done, done}, 2'b01);
            if (exp_q.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                logic [15:0] e;
                int unsigned ac;
                e  = exp_q.pop_front();
                ac = acc_cyc_q.pop_front();
                check("p", p, e);
                check("ready_at_done", ready, 1);
                check("latency_edges", cyc - ac, W + 1);
            end
        end
        prev_done = done;
    end

    task automatic wait_ready();
        for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s);
        wait_ready();
        a = x; b = y; sgn = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic s);
        issue(x, y, s);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n0, k;
        logic [15:0] exp_clr;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; acc_clr = 1'b0; a = '0; b = '0;
        start16 = 1'b0; sgn16 = 1'b0; acc_clr16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_p", p, 0);
        check("rst_p16", p16, 0);
        rst = 1'b0;
        @(negedge clk);

        op(8'hFF, 8'hFF, 1'b0);
`ifndef VMSU_MAC_EN
        check("p_255x255", p, 16'hFE01);
`endif
        op(8'h80, 8'h80, 1'b1);
`ifndef VMSU_MAC_EN
        check("p_m128xm128", p, 16'h4000);
`endif
        op(8'hFD, 8'h05, 1'b1);
`ifndef VMSU_MAC_EN
        check("p_m3x5", p, 16'hFFF1);
`endif
        op(8'h80, 8'h02, 1'b0);
`ifndef VMSU_MAC_EN
        check("p_80x02", p, 16'h0100);
`endif

        // acc_clr in IDLE: clears only in MAC builds, never pulses done
`ifdef VMSU_MAC_EN
        exp_clr = '0;
`else
        exp_clr = p;
`endif
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("acc_clr_done", done, 0);
        check("acc_clr_p", p, exp_clr);

        op(8'd3, 8'd4, 1'b0);
        check("p_3x4", p, 16'd12);
        op(8'd5, 8'd6, 1'b0);
`ifdef VMSU_MAC_EN
        check("p_acc_5x6", p, 16'd42);
`else
        check("p_5x6", p, 16'd30);
`endif
        acc_clr = 1'b1;
        issue(8'd2, 8'd2, 1'b0);
        acc_clr = 1'b0;
        drain();
        check("p_clr_start_2x2", p, 16'd4);

        // Back-to-back with start held high
        wait_ready();
        d0 = n_done; n0 = n_accept;
        a = 8'd3; b = 8'd7; sgn = 1'b0; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (n_accept == n0 + 1) begin a = 8'd4; b = 8'd4; end
            if (n_accept >= n0 + 2) break;
        end
        start = 1'b0;
        drain();
        check("b2b_done_count", n_done - d0, 2);
        check("b2b_spacing", last_done_cyc - prev_done_cyc, W + 2);
`ifndef VMSU_MAC_EN
        check("p_b2b_4x4", p, 16'd16);
`endif

        // start pulsed while busy is ignored
        d0 = n_done; n0 = n_accept;
        issue(8'd9, 8'd9, 1'b0);
        repeat (3) @(negedge clk);
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        check("mid_start_done_count", n_done - d0, 1);
        check("mid_start_accepts", n_accept - n0, 1);

        // Reset mid-CALC
        d0 = n_done;
        issue(8'd9, 8'd11, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_p", p, 0);
        check("midrst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_done", n_done - d0, 0);
        op(8'd6, 8'd7, 1'b0);
        check("p_6x7_after_rst", p, 16'd42);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            op(x, y, 1'($urandom_range(0, 1)));
        end

        // WIDTH=16 directed case
        a16 = 16'h8000; b16 = 16'h7FFF; sgn16 = 1'b1; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            k++;
            if (done16) break;
        end
        check("done16_seen", done16, 1);
        check("lat16", k, 18);
        check("p16", p16, 32'hC0008000);
        check("ready16_at_done", ready16, 1);
        @(negedge clk);
        check("done16_single", done16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
